// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: instruction-memory handshake, decode handshake, and control inputs.
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt;
    logic [31:0] pc_out;
    logic        fault;

    // master = fetch sequencer, slave = memory/decode/control environment
    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, pc_out, fault,
        input  imem_ack, imem_rdata, stall, redirect_valid, redirect_target, halt
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc_out, fault,
        output imem_ack, imem_rdata, stall, redirect_valid, redirect_target, halt
    );
endinterface

// File: rtl/fetch_sequencer.sv
// RV32I fetch sequencer: owns the PC, issues imem requests, hands words to decode,
// and applies redirects, halts and sticky fault detection.
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned MAX_WAIT     = 15
) (
    input logic     clk,
    input logic     reset,
    fetch_if.master bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DELIVER,
        S_HALTED,
        S_FAULT
    } state_t;

    state_t            state, state_next;
    logic [XLEN-1:0]   pc, pc_next;
    logic [XLEN-1:0]   instr_q, instr_next;
    logic [XLEN-1:0]   ipc_q, ipc_next;
    logic              valid_q, valid_next;
    logic              fault_q, fault_next;
    logic [CNT_W-1:0]  cnt, cnt_next, cnt_inc;
    logic              active_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control; halt beats redirect beats ack/stall
    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = instr_q;
        ipc_next   = ipc_q;
        valid_next = valid_q;
        fault_next = fault_q;
        cnt_next   = cnt;
        cnt_inc    = cnt + CNT_W'(1);
        active_c   = (state == S_IDLE) || (state == S_FETCH) || (state == S_DELIVER);

        if (active_c) begin
            if (bus.halt) begin
                state_next = S_HALTED;
                valid_next = 1'b0;
            end else if (bus.redirect_valid) begin
                valid_next = 1'b0;
                if (bus.redirect_target[1:0] != 2'b00) begin
                    state_next = S_FAULT;
                    fault_next = 1'b1;
                end else begin
                    pc_next    = bus.redirect_target;
                    cnt_next   = '0;
                    state_next = S_FETCH;
                end
            end else begin
                case (state)
                    S_IDLE: state_next = S_FETCH;
                    S_FETCH: begin
                        if (bus.imem_ack) begin
                            instr_next = bus.imem_rdata;
                            ipc_next   = pc;
                            pc_next    = pc + XLEN'(4);
                            valid_next = 1'b1;
                            cnt_next   = '0;
                            state_next = S_DELIVER;
                        end else if (cnt_inc == CNT_W'(MAX_WAIT)) begin
                            cnt_next   = cnt_inc;
                            fault_next = 1'b1;
                            state_next = S_FAULT;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end
                    S_DELIVER: begin
                        if (!bus.stall) begin
                            valid_next = 1'b0;
                            state_next = S_FETCH;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_VECTOR;
            instr_q <= NOP;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            cnt     <= '0;
        end else begin
            pc      <= pc_next;
            instr_q <= instr_next;
            ipc_q   <= ipc_next;
            valid_q <= valid_next;
            fault_q <= fault_next;
            cnt     <= cnt_next;
        end
    end

    assign bus.imem_req    = (state == S_FETCH);
    assign bus.imem_addr   = pc;
    assign bus.pc_out      = pc;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = ipc_q;
    assign bus.instr_valid = valid_q;
    assign bus.fault       = fault_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized
// run scored against a transaction-level model of the fetched instruction stream.
module tb_fetch_sequencer;
    localparam logic [31:0] WRAP_VECTOR = 32'hFFFF_FFFC;
    localparam logic [31:0] NOP         = 32'h0000_0013;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    fetch_if bus();
    fetch_if bus2();

    fetch_sequencer #(.RESET_VECTOR(32'h0000_0000), .MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    fetch_sequencer #(.RESET_VECTOR(WRAP_VECTOR), .MAX_WAIT(15)) dut_wrap (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: an arbitrary address-dependent word
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic idle_inputs();
        bus.imem_ack = 1'b0;  bus.imem_rdata = '0;  bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;  bus.redirect_target = '0;  bus.halt = 1'b0;
        bus2.imem_ack = 1'b0; bus2.imem_rdata = '0; bus2.stall = 1'b0;
        bus2.redirect_valid = 1'b0; bus2.redirect_target = '0; bus2.halt = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL reset_idle_req: got %b want 0", bus.imem_req); else n_pass++;
        for (int c = 0; c < 10 && !bus.instr_valid; c++) begin
            @(negedge clk);
            bus.imem_ack = bus.imem_req;
            bus.imem_rdata = mem_word(bus.imem_addr);
        end
        n_checks++; if (bus.instr_valid !== 1'b1) $display("FAIL reset_pre_valid: got %b want 1", bus.instr_valid); else n_pass++;
        bus.stall = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.pc_out !== 32'h0) $display("FAIL reset_pc: got %h want 00000000", bus.pc_out); else n_pass++;
        n_checks++; if (bus.instr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.instr_valid); else n_pass++;
        n_checks++; if (bus.instr !== NOP) $display("FAIL reset_instr: got %h want %h", bus.instr, NOP); else n_pass++;
        n_checks++; if (bus.instr_pc !== 32'h0) $display("FAIL reset_instr_pc: got %h want 0", bus.instr_pc); else n_pass++;
        n_checks++; if (bus.fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", bus.fault); else n_pass++;
        n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.imem_req); else n_pass++;
        reset = 1'b0;
        bus.stall = 1'b0;
    endtask

    task automatic test_sequential();
        int nreq;
        int ndel;
        int age;
        reset_dut();
        nreq = 0; ndel = 0; age = 0;
        for (int c = 0; c < 40 && ndel < 3; c++) begin
            @(negedge clk);
            bus.imem_ack = 1'b0;
            if (bus.instr_valid) begin
                n_checks++; if (bus.instr_pc !== 32'(4 * ndel)) $display("FAIL seq_instr_pc: got %h want %h", bus.instr_pc, 32'(4 * ndel)); else n_pass++;
                n_checks++; if (bus.instr !== mem_word(32'(4 * ndel))) $display("FAIL seq_instr: got %h want %h", bus.instr, mem_word(32'(4 * ndel))); else n_pass++;
                if (ndel == 0) begin
                    n_checks++; if (bus.pc_out !== 32'h4) $display("FAIL seq_pc_after_ack: got %h want 00000004", bus.pc_out); else n_pass++;
                end
                ndel++;
            end
            if (bus.imem_req) begin
                if (age == 0) begin
                    n_checks++; if (bus.imem_addr !== 32'(4 * nreq)) $display("FAIL seq_addr: got %h want %h", bus.imem_addr, 32'(4 * nreq)); else n_pass++;
                    nreq++;
                end
                if (age >= 1) begin
                    bus.imem_ack = 1'b1;
                    bus.imem_rdata = mem_word(bus.imem_addr);
                    age = 0;
                end else begin
                    age++;
                end
            end
        end
        n_checks++; if (ndel != 3) $display("FAIL seq_timeout: delivered %0d want 3", ndel); else n_pass++;
    endtask

    task automatic test_stall();
        logic [31:0] hold_instr;
        logic [31:0] hold_pc;
        reset_dut();
        for (int c = 0; c < 10 && !bus.instr_valid; c++) begin
            @(negedge clk);
            bus.imem_ack = bus.imem_req;
            bus.imem_rdata = mem_word(bus.imem_addr);
        end
        n_checks++; if (bus.instr_valid !== 1'b1) $display("FAIL stall_pre_valid: got %b want 1", bus.instr_valid); else n_pass++;
        hold_instr = bus.instr;
        hold_pc = bus.instr_pc;
        bus.stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (bus.instr_valid !== 1'b1) $display("FAIL stall_valid: got %b want 1", bus.instr_valid); else n_pass++;
            n_checks++; if (bus.instr !== mem_word(32'h0) || bus.instr !== hold_instr) $display("FAIL stall_instr: got %h want %h", bus.instr, mem_word(32'h0)); else n_pass++;
            n_checks++; if (bus.instr_pc !== 32'h0 || bus.instr_pc !== hold_pc) $display("FAIL stall_instr_pc: got %h want 0", bus.instr_pc); else n_pass++;
            n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL stall_req: got %b want 0", bus.imem_req); else n_pass++;
            if (c == 2) bus.stall = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (bus.instr_valid !== 1'b0) $display("FAIL stall_release_valid: got %b want 0", bus.instr_valid); else n_pass++;
        n_checks++; if (bus.imem_req !== 1'b1) $display("FAIL stall_release_req: got %b want 1", bus.imem_req); else n_pass++;
        n_checks++; if (bus.imem_addr !== 32'h4) $display("FAIL stall_release_addr: got %h want 00000004", bus.imem_addr); else n_pass++;
    endtask

    task automatic test_redirect_ack();
        bit found;
        reset_dut();
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clk);
            bus.imem_ack = 1'b0;
            n_checks++; if (bus.pc_out === 32'hC) $display("FAIL redir_pc_never_c: got %h want not 0000000c", bus.pc_out); else n_pass++;
            if (bus.imem_req) begin
                bus.imem_ack = 1'b1;
                bus.imem_rdata = mem_word(bus.imem_addr);
                if (bus.imem_addr === 32'h8) begin
                    bus.redirect_valid = 1'b1;
                    bus.redirect_target = 32'h40;
                    found = 1'b1;
                end
            end
        end
        n_checks++; if (!found) $display("FAIL redir_reach_8: got no fetch of 00000008 want one"); else n_pass++;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        n_checks++; if (bus.instr_valid !== 1'b0) $display("FAIL redir_valid: got %b want 0", bus.instr_valid); else n_pass++;
        n_checks++; if (bus.imem_req !== 1'b1) $display("FAIL redir_req: got %b want 1", bus.imem_req); else n_pass++;
        n_checks++; if (bus.imem_addr !== 32'h40) $display("FAIL redir_addr: got %h want 00000040", bus.imem_addr); else n_pass++;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = mem_word(32'h40);
        @(negedge clk);
        bus.imem_ack = 1'b0;
        n_checks++; if (bus.instr_pc !== 32'h40) $display("FAIL redir_instr_pc: got %h want 00000040", bus.instr_pc); else n_pass++;
        n_checks++; if (bus.instr !== mem_word(32'h40)) $display("FAIL redir_instr: got %h want %h", bus.instr, mem_word(32'h40)); else n_pass++;
    endtask

    task automatic test_misaligned();
        reset_dut();
        @(negedge clk);
        n_checks++; if (bus.imem_req !== 1'b1) $display("FAIL mis_pre_req: got %b want 1", bus.imem_req); else n_pass++;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h42;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        n_checks++; if (bus.fault !== 1'b1) $display("FAIL mis_fault: got %b want 1", bus.fault); else n_pass++;
        n_checks++; if (bus.pc_out !== 32'h0) $display("FAIL mis_pc: got %h want 00000000", bus.pc_out); else n_pass++;
        for (int c = 0; c < 8; c++) begin
            bus.imem_ack = 1'b1;
            bus.redirect_valid = 1'b1;
            bus.redirect_target = 32'h100;
            @(negedge clk);
            n_checks++; if (bus.imem_req !== 1'b0 || bus.fault !== 1'b1) $display("FAIL mis_stuck: got req=%b fault=%b want req=0 fault=1", bus.imem_req, bus.fault); else n_pass++;
        end
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_checks++; if (bus.fault !== 1'b0) $display("FAIL mis_reset_fault: got %b want 0", bus.fault); else n_pass++;
        n_checks++; if (bus.pc_out !== 32'h0) $display("FAIL mis_reset_pc: got %h want 00000000", bus.pc_out); else n_pass++;
    endtask

    task automatic test_timeout();
        int nreq;
        reset_dut();
        nreq = 0;
        for (int c = 0; c < 40 && !bus.fault; c++) begin
            @(negedge clk);
            bus.imem_ack = 1'b0;
            if (bus.imem_req) nreq++;
        end
        n_checks++; if (bus.fault !== 1'b1) $display("FAIL timeout_fault: got %b want 1", bus.fault); else n_pass++;
        n_checks++; if (nreq != 15) $display("FAIL timeout_cycles: got %0d want 15", nreq); else n_pass++;
        n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL timeout_req: got %b want 0", bus.imem_req); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr;
        int n;
        reset_dut();
        exp_addr = WRAP_VECTOR;
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            @(negedge clk);
            bus2.imem_ack = 1'b0;
            if (bus2.imem_req) begin
                n_checks++; if (bus2.imem_addr !== exp_addr) $display("FAIL wrap_addr: got %h want %h", bus2.imem_addr, exp_addr); else n_pass++;
                bus2.imem_ack = 1'b1;
                bus2.imem_rdata = mem_word(bus2.imem_addr);
                exp_addr = exp_addr + 32'd4;
                n++;
            end
        end
        @(negedge clk);
        bus2.imem_ack = 1'b0;
        n_checks++; if (n != 2) $display("FAIL wrap_count: got %0d want 2", n); else n_pass++;
        n_checks++; if (bus2.instr_pc !== 32'h0) $display("FAIL wrap_instr_pc: got %h want 00000000", bus2.instr_pc); else n_pass++;
        n_checks++; if (bus2.pc_out !== 32'h4) $display("FAIL wrap_pc: got %h want 00000004", bus2.pc_out); else n_pass++;
        n_checks++; if (bus2.fault !== 1'b0) $display("FAIL wrap_fault: got %b want 0", bus2.fault); else n_pass++;
    endtask

    task automatic test_halt();
        logic [31:0] frozen;
        reset_dut();
        for (int c = 0; c < 10 && !bus.instr_valid; c++) begin
            @(negedge clk);
            bus.imem_ack = bus.imem_req;
            bus.imem_rdata = mem_word(bus.imem_addr);
        end
        n_checks++; if (bus.instr_valid !== 1'b1) $display("FAIL halt_pre_valid: got %b want 1", bus.instr_valid); else n_pass++;
        frozen = bus.pc_out;
        bus.stall = 1'b1;
        bus.halt = 1'b1;
        @(negedge clk);
        bus.halt = 1'b0;
        n_checks++; if (bus.instr_valid !== 1'b0) $display("FAIL halt_valid: got %b want 0", bus.instr_valid); else n_pass++;
        n_checks++; if (bus.pc_out !== 32'h4) $display("FAIL halt_pc: got %h want 00000004", bus.pc_out); else n_pass++;
        for (int c = 0; c < 10; c++) begin
            bus.redirect_valid = (c == 3);
            bus.redirect_target = 32'h80;
            bus.imem_ack = 1'b1;
            bus.imem_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
            n_checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) $display("FAIL halt_quiet: got req=%b valid=%b want 0/0", bus.imem_req, bus.instr_valid); else n_pass++;
            n_checks++; if (bus.pc_out !== frozen || bus.fault !== 1'b0) $display("FAIL halt_frozen: got pc=%h fault=%b want pc=%h fault=0", bus.pc_out, bus.fault, frozen); else n_pass++;
        end
        idle_inputs();
    endtask

    // Randomized traffic: model is the expected address of the next fetch and a queue
    // of fetched addresses awaiting consumption by decode.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] exp_ipc;
        logic [31:0] target;
        logic [31:0] pend_q[$];
        int wait_left;
        int delivered;
        int errs;
        reset_dut();
        exp_pc = 32'h0;
        wait_left = -1;
        delivered = 0;
        errs = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.imem_ack = 1'b0;
            bus.redirect_valid = 1'b0;
            bus.stall = 1'b0;
            if (bus.imem_req && bus.instr_valid) begin
                n_checks++; $display("FAIL rand_req_and_valid: got req=1 valid=1 want not both"); errs++;
            end
            if (bus.imem_req) begin
                n_checks++; if (bus.imem_addr !== exp_pc) begin $display("FAIL rand_addr: got %h want %h", bus.imem_addr, exp_pc); errs++; end else n_pass++;
                if (wait_left < 0) wait_left = int'($urandom_range(0, 6));
                if (wait_left == 0) begin
                    bus.imem_ack = 1'b1;
                    bus.imem_rdata = mem_word(bus.imem_addr);
                    wait_left = -1;
                end else begin
                    wait_left--;
                end
            end
            if (!bus.instr_valid && $urandom_range(0, 19) == 0) begin
                target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC);
                bus.redirect_valid = 1'b1;
                bus.redirect_target = target;
                exp_pc = target;
                wait_left = -1;
            end else if (bus.imem_ack) begin
                pend_q.push_back(exp_pc);
                exp_pc = exp_pc + 32'd4;
            end
            if (bus.instr_valid) begin
                bus.stall = ($urandom_range(0, 2) == 0);
                if (!bus.stall) begin
                    n_checks++;
                    if (pend_q.size() == 0) begin
                        $display("FAIL rand_unexpected_instr: got instr_pc=%h want no instruction", bus.instr_pc); errs++;
                    end else begin
                        exp_ipc = pend_q.pop_front();
                        if (bus.instr_pc !== exp_ipc || bus.instr !== mem_word(exp_ipc)) begin
                            $display("FAIL rand_instr: got pc=%h instr=%h want pc=%h instr=%h", bus.instr_pc, bus.instr, exp_ipc, mem_word(exp_ipc));
                            errs++;
                        end else n_pass++;
                        delivered++;
                    end
                end
            end
            if (errs > 20) break;
        end
        bus.stall = 1'b0;
        n_checks++; if (bus.fault !== 1'b0) $display("FAIL rand_fault: got %b want 0", bus.fault); else n_pass++;
        n_checks++; if (delivered < 100) $display("FAIL rand_throughput: got %0d delivered want >=100", delivered); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_ack();
        test_misaligned();
        test_timeout();
        test_wrap();
        test_halt();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controller that sequences the RV32I program counter and instruction fetch. It owns the PC register and drives a request/acknowledge handshake to instruction memory. It presents each fetched word to decode with a valid/stall handshake, and applies branch/jump redirects, halts and fault detection. It sits between the PC/instruction-memory datapath and the decode stage.

Parameters:
RESET_VECTOR, 32'h00000000, PC value loaded on reset.
MAX_WAIT, 15, cycles FETCH may wait for imem_ack before declaring a timeout fault (≥1).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
imem_req  out  1  fetch request, high only in FETCH.
imem_addr  out  32  fetch address; equals pc_out; meaningful only while imem_req=1.
imem_ack  in  1  memory has returned imem_rdata this cycle; ignored when imem_req=0.
imem_rdata  in  32  fetched instruction word.
instr_valid  out  1  instr/instr_pc hold a valid instruction for decode.
instr  out  32  registered instruction word.
instr_pc  out  32  address instr was fetched from.
stall  in  1  decode cannot accept; instruction is consumed on instr_valid && !stall.
redirect_valid  in  1  branch/jump taken; load redirect_target.
redirect_target  in  32  new PC.
halt  in  1  ecall/ebreak halt request.
pc_out  out  32  current PC (next fetch address).
fault  out  1  sticky: misaligned redirect or fetch timeout.

Behaviour:
- Synchronous reset (highest priority): pc=RESET_VECTOR, state=IDLE, instr_valid=0, instr=32'h00000013 (NOP), instr_pc=0, fault=0, wait counter=0. Reset mid-operation abandons any outstanding request.
- States: IDLE, FETCH, DELIVER, HALTED, FAULT. imem_req=(state==FETCH), combinational.
- IDLE: one cycle, then -> FETCH.
- FETCH: while imem_ack=0, wait counter increments. When the counter reaches MAX_WAIT without ack -> FAULT, fault=1. On imem_ack: instr<=imem_rdata, instr_pc<=pc, pc<=pc+4, instr_valid<=1, counter cleared -> DELIVER. Ack in the same cycle as req is legal (zero-wait memory).
- DELIVER: imem_req=0. If stall=1, hold instr_valid/instr/instr_pc unchanged. If stall=0, the instruction is consumed this cycle; next cycle instr_valid=0, -> FETCH. Peak throughput is one instruction per 2 cycles.
- PC arithmetic is modulo 2^32: 32'hFFFFFFFC+4 = 0. No fault on wrap.
- Priority within a cycle: reset > halt > redirect > ack/stall.
- redirect_valid in IDLE/FETCH/DELIVER: if redirect_target[1:0]!=0 -> FAULT, fault=1, pc unchanged. Otherwise pc<=redirect_target, instr_valid<=0, counter cleared -> FETCH. A simultaneous imem_ack is discarded: no instr update, no pc+4. Redirect overrides stall and drops the held instruction.
- halt in IDLE/FETCH/DELIVER: -> HALTED, instr_valid<=0, pc frozen, any ack that cycle is discarded.
- HALTED and FAULT: imem_req=0, instr_valid=0, pc frozen; redirect/halt/ack are ignored. Only reset exits either state. fault stays 1 in FAULT.
- Counter width is $clog2(MAX_WAIT+1).

Test Plan:
- Reset held 2 cycles, memory acks 1 cycle after req returning addr-dependent data -> imem_addr sequence 0x0,0x4,0x8; instr_pc matches each word; pc_out=0x4 in the cycle after the first ack.
- Stall held 3 cycles while instr_valid=1 -> instr/instr_pc stable, imem_req=0 throughout; the next fetch starts the cycle after stall drops.
- redirect_valid with target 0x40 in the same cycle as imem_ack for 0x8 -> word discarded, instr_valid=0, next imem_addr=0x40, pc_out never 0xC.
- Redirect to 0x42 -> fault=1 next cycle, imem_req=0 forever; reset restores fault=0, pc_out=RESET_VECTOR.
- imem_ack never asserted with MAX_WAIT=15 -> fault=1 after 15 FETCH cycles. Separately, RESET_VECTOR=32'hFFFFFFFC -> second imem_addr=0x0.
- halt during DELIVER with stall=1 -> instr_valid=0, pc frozen, no requests for 10 cycles; a redirect in HALTED has no effect.
